// File: rtl/branch_predictor_pkg.sv
// ---------------------------------------------------------------------------
// branch_predictor_pkg
// Purpose : Shared definitions for the branch direction predictor and the
//           EX-stage branch resolver.
//           - BRANCH_* control codes carried from ID/EX. Codes 5-7 are
//             undefined and behave as NOP.
//           - The 2-bit saturating counter type and its reset value,
//             CNT_WNT (weakly not-taken).
//           - A saturating counter update helper.
// Ports   : none (package)
// ---------------------------------------------------------------------------
package branch_predictor_pkg;

  typedef enum logic [2:0] {
    BRANCH_NOP = 3'd0,
    BRANCH_EQ  = 3'd1,
    BRANCH_NEQ = 3'd2,
    BRANCH_LTZ = 3'd3,
    BRANCH_GTZ = 3'd4
  } branch_ctrl_t;

  typedef logic [1:0] cnt_t;

  localparam cnt_t CNT_SNT = 2'b00;  // strongly not-taken
  localparam cnt_t CNT_WNT = 2'b01;  // weakly not-taken, reset value
  localparam cnt_t CNT_STK = 2'b11;  // strongly taken

  // Move the counter one step toward the resolved direction, holding at
  // either end rather than wrapping.
  function automatic cnt_t cnt_update(input cnt_t c, input logic taken);
    cnt_t r;
    r = c;
    if (taken) begin
      if (c != CNT_STK) r = c + 2'b01;
    end else begin
      if (c != CNT_SNT) r = c - 2'b01;
    end
    return r;
  endfunction

endpackage

// File: rtl/branch_predictor_cond_eval.sv
// ---------------------------------------------------------------------------
// branch_cond_eval
// Purpose : Combinational branch condition table. Maps the ID/EX branch
//           control code and the ALU flags to the resolved direction.
//           Codes that do not name a branch (NOP and the undefined codes
//           5-7) report "not a branch" and not-taken.
// Ports   :
//   i_ctrl      in  3  BRANCH_* code
//   i_zero      in  1  ALU zero flag
//   i_negative  in  1  ALU negative flag
//   o_taken     out 1  resolved direction
//   o_is_branch out 1  code names a real conditional branch
// ---------------------------------------------------------------------------
module branch_cond_eval
  import branch_predictor_pkg::*;
(
  input  logic [2:0] i_ctrl,
  input  logic       i_zero,
  input  logic       i_negative,
  output logic       o_taken,
  output logic       o_is_branch
);

  always_comb begin
    o_taken     = 1'b0;
    o_is_branch = 1'b0;
    case (i_ctrl)
      BRANCH_EQ: begin
        o_is_branch = 1'b1;
        o_taken     = i_zero;
      end
      BRANCH_NEQ: begin
        o_is_branch = 1'b1;
        o_taken     = ~i_zero;
      end
      BRANCH_LTZ: begin
        // "less than or equal to zero": negative or exactly zero
        o_is_branch = 1'b1;
        o_taken     = i_negative | i_zero;
      end
      BRANCH_GTZ: begin
        o_is_branch = 1'b1;
        o_taken     = ~(i_negative | i_zero);
      end
      default: begin
        o_is_branch = 1'b0;
        o_taken     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Purpose : Dynamic direction predictor and EX-stage branch resolver.
//           IF looks up a table of 2-bit saturating counters with zero
//           latency. EX resolves the branch condition, flags a mispredict
//           against the prediction carried down the pipe, and trains the
//           counter at the carried index.
//           MODE=0 indexes the table by PC (bimodal). MODE=1 XORs the PC
//           index with a non-speculative global history register (gshare).
// Optional: define BRANCH_PERF_EN to add the perf_branches / perf_mispred
//           counters and ports. Without it they do not exist.
// Ports   :
//   clk            in  1      pipeline clock
//   rst_n          in  1      asynchronous active-low reset
//   if_pc          in  PC_W   PC of the instruction in IF
//   if_pred_taken  out 1      prediction for if_pc (combinational)
//   if_pred_idx    out IDX_W  table index used for if_pc
//   ex_valid       in  1      EX holds a real instruction
//   ex_stall       in  1      EX frozen; no training this cycle
//   ex_branch_ctrl in  3      BRANCH_* code
//   ex_zero        in  1      ALU zero flag
//   ex_negative    in  1      ALU negative flag
//   ex_pred_taken  in  1      prediction made in IF for this instruction
//   ex_pred_idx    in  IDX_W  index used in IF for this instruction
//   ex_taken       out 1      resolved direction (combinational)
//   ex_mispredict  out 1      resolved direction differs from prediction
//   perf_branches  out 32     [BRANCH_PERF_EN] resolved-branch count
//   perf_mispred   out 32     [BRANCH_PERF_EN] mispredict count
// ---------------------------------------------------------------------------
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_W  = 6,
  parameter int HIST_W = 6,
  parameter int MODE   = 0,
  parameter int PC_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PC_W-1:0]  if_pc,
  output logic             if_pred_taken,
  output logic [IDX_W-1:0] if_pred_idx,
  input  logic             ex_valid,
  input  logic             ex_stall,
  input  logic [2:0]       ex_branch_ctrl,
  input  logic             ex_zero,
  input  logic             ex_negative,
  input  logic             ex_pred_taken,
  input  logic [IDX_W-1:0] ex_pred_idx,
  output logic             ex_taken,
  output logic             ex_mispredict
`ifdef BRANCH_PERF_EN
  ,
  output logic [31:0]      perf_branches,
  output logic [31:0]      perf_mispred
`endif
);

  localparam int DEPTH = 2 ** IDX_W;

  cnt_t             r_cnt [DEPTH];
  logic [IDX_W-1:0] w_pc_idx;
  logic [IDX_W-1:0] w_hist_idx;
  logic             w_taken;
  logic             w_is_branch;
  logic             w_train;
  logic             w_unused_pc;

  // Instructions are word aligned, so the two low PC bits carry no
  // information; the bits above the index are simply aliased.
  assign w_pc_idx    = if_pc[IDX_W+1:2];
  assign w_unused_pc = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0]};

  branch_cond_eval u_cond (
    .i_ctrl      (ex_branch_ctrl),
    .i_zero      (ex_zero),
    .i_negative  (ex_negative),
    .o_taken     (w_taken),
    .o_is_branch (w_is_branch)
  );

  assign ex_taken      = w_taken;
  assign ex_mispredict = ex_valid & w_is_branch & (w_taken != ex_pred_taken);

  // A stalled EX will present the same branch again next cycle, so it is
  // only counted once: on the cycle it actually leaves EX.
  assign w_train = ex_valid & ~ex_stall & w_is_branch;

  // Global history is updated only at resolve time, so it never needs
  // repair after a flush.
  generate
    if (MODE == 1) begin : g_gshare
      logic [HIST_W-1:0] r_ghr;

      if (HIST_W > 1) begin : g_shift
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_ghr <= '0;
          end else if (w_train) begin
            r_ghr <= {r_ghr[HIST_W-2:0], w_taken};
          end
        end
      end else begin : g_single
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            r_ghr <= '0;
          end else if (w_train) begin
            r_ghr <= w_taken;
          end
        end
      end

      // History is zero-extended at the top to the index width.
      assign w_hist_idx = IDX_W'(r_ghr);
    end else begin : g_bimodal
      assign w_hist_idx = '0;
    end
  endgenerate

  assign if_pred_idx = w_pc_idx ^ w_hist_idx;

  // No write-to-read bypass: an IF lookup in the same cycle as an EX update
  // of that entry sees the pre-update counter.
  assign if_pred_taken = rst_n & r_cnt[if_pred_idx][1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_cnt[i] <= CNT_WNT;
      end
    end else if (w_train) begin
      r_cnt[ex_pred_idx] <= cnt_update(r_cnt[ex_pred_idx], w_taken);
    end
  end

`ifdef BRANCH_PERF_EN
  logic [31:0] r_perf_branches;
  logic [31:0] r_perf_mispred;

  // Free-running 32-bit counters; wrap-around is expected on long runs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_branches <= '0;
      r_perf_mispred  <= '0;
    end else if (w_train) begin
      r_perf_branches <= r_perf_branches + 32'd1;
      if (ex_mispredict) begin
        r_perf_mispred <= r_perf_mispred + 32'd1;
      end
    end
  end

  assign perf_branches = r_perf_branches;
  assign perf_mispred  = r_perf_mispred;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
// Two predictors share every input: a bimodal instance (MODE=0, HIST_W=6)
// and a gshare instance (MODE=1, HIST_W=4). A reference model of the counter
// table and of the gshare history is trained alongside them; expected
// values are pushed to a scoreboard queue when stimulus is driven and popped
// when the outputs are sampled, one clock phase away from the active edge.
// Perf-counter checks are included when BRANCH_PERF_EN is defined.
// ---------------------------------------------------------------------------
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] if_pc;
  logic        ex_valid, ex_stall;
  logic [2:0]  ex_ctrl;
  logic        ex_zero, ex_neg, ex_pred;
  logic [5:0]  ex_idx;

  logic        b_pred, g_pred, b_taken, g_taken, b_mp, g_mp;
  logic [5:0]  b_idx, g_idx;
`ifdef BRANCH_PERF_EN
  logic [31:0] b_pbr, b_pmp, g_pbr, g_pmp;
`endif

  always #5 clk = ~clk;

  branch_predictor #(.IDX_W(6), .HIST_W(6), .MODE(0), .PC_W(32)) u_bim (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
    .if_pred_taken(b_pred), .if_pred_idx(b_idx),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_branch_ctrl(ex_ctrl),
    .ex_zero(ex_zero), .ex_negative(ex_neg), .ex_pred_taken(ex_pred),
    .ex_pred_idx(ex_idx), .ex_taken(b_taken), .ex_mispredict(b_mp)
`ifdef BRANCH_PERF_EN
    , .perf_branches(b_pbr), .perf_mispred(b_pmp)
`endif
  );

  branch_predictor #(.IDX_W(6), .HIST_W(4), .MODE(1), .PC_W(32)) u_gsh (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
    .if_pred_taken(g_pred), .if_pred_idx(g_idx),
    .ex_valid(ex_valid), .ex_stall(ex_stall), .ex_branch_ctrl(ex_ctrl),
    .ex_zero(ex_zero), .ex_negative(ex_neg), .ex_pred_taken(ex_pred),
    .ex_pred_idx(ex_idx), .ex_taken(g_taken), .ex_mispredict(g_mp)
`ifdef BRANCH_PERF_EN
    , .perf_branches(g_pbr), .perf_mispred(g_pmp)
`endif
  );

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [1:0] m_cnt [64];
  logic [3:0] m_ghr;
  int         m_br, m_mp;

  function automatic logic cond_model(input logic [2:0] c, input logic z, input logic n);
    case (c)
      3'd1:    return z;
      3'd2:    return !z;
      3'd3:    return n || z;
      3'd4:    return !(n || z);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic mp_model(input logic v, input logic [2:0] c, input logic t, input logic p);
    return v && (c >= 3'd1) && (c <= 3'd4) && (t != p);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 64; i++) m_cnt[i] = 2'b01;
    m_ghr = 4'd0;
    m_br  = 0;
    m_mp  = 0;
  endtask

  task automatic m_train(input logic [5:0] idx, input logic t, input logic mp);
    if (t) begin
      if (m_cnt[idx] != 2'b11) m_cnt[idx] = m_cnt[idx] + 2'd1;
    end else begin
      if (m_cnt[idx] != 2'b00) m_cnt[idx] = m_cnt[idx] - 2'd1;
    end
    m_ghr = {m_ghr[2:0], t};
    m_br++;
    if (mp) m_mp++;
  endtask

  task automatic drive(input logic [2:0] c, input logic z, input logic n, input logic p,
                       input logic [5:0] idx, input logic v, input logic s);
    ex_ctrl = c; ex_zero = z; ex_neg = n; ex_pred = p;
    ex_idx = idx; ex_valid = v; ex_stall = s;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    if_pc = 32'h40;
    drive(3'd0, 0, 0, 0, 6'd0, 0, 0);
    #1 rst_n = 1'b0;
    m_reset();
    #2;
    sb.push_back('{"rst_low_pred", 32'd0});
    e = sb.pop_front(); n_cmp++;
    if (32'(b_pred) !== e.exp) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, b_pred, e.exp); end
    @(negedge clk); rst_n = 1'b1; #1;
    sb.push_back('{"rst_pred", 32'(m_cnt[6'h10][1])});
    sb.push_back('{"rst_idx", 32'h10});
    sb.push_back('{"rst_gidx", 32'h10});
    e = sb.pop_front(); n_cmp++;
    if (32'(b_pred) !== e.exp) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, b_pred, e.exp); end
    e = sb.pop_front(); n_cmp++;
    if (32'(b_idx) !== e.exp) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, b_idx, e.exp); end
    e = sb.pop_front(); n_cmp++;
    if (32'(g_idx) !== e.exp) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, g_idx, e.exp); end
`ifdef BRANCH_PERF_EN
    sb.push_back('{"rst_perf_br", 32'd0});
    sb.push_back('{"rst_perf_mp", 32'd0});
    e = sb.pop_front(); n_cmp++;
    if (b_pbr !== e.exp) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, b_pbr, e.exp); end
    e = sb.pop_front(); n_cmp++;
    if (b_pmp !== e.exp) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, b_pmp, e.exp); end
`endif
  endtask

  task automatic test_decode();
    logic [2:0] ct [10];
    logic       zt [10];
    logic       nt [10];
    logic       pt [10];
    logic       t;
    ct = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd7, 3'd0};
    zt = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    nt = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    pt = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      // stalled EX: outcome and mispredict are live but nothing trains
      drive(ct[i], zt[i], nt[i], pt[i], 6'h3F, 1, 1);
      #1;
      t = cond_model(ct[i], zt[i], nt[i]);
      sb.push_back('{$sformatf("dec%0d_taken", i), 32'(t)});
      sb.push_back('{$sformatf("dec%0d_mp", i), 32'(mp_model(1'b1, ct[i], t, pt[i]))});
      e = sb.pop_front(); n_cmp++;
      if (32'(b_taken) !== e.exp) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, b_taken, e.exp); end
      e = sb.pop_front(); n_cmp++;
      if (32'(b_mp) !== e.exp) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, b_mp, e.exp); end
    end
  endtask

  task automatic test_train();
    logic tt [8];
    logic p;
    tt = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if_pc = 32'h40;
      p = (i < 2) ? 1'b0 : m_cnt[6'h10][1];
      drive(3'd1, tt[i], 0, p, 6'h10, 1, 0);
      #1;
      // IF lookup of the entry being written sees the old counter
      sb.push_back('{$sformatf("train%0d_pred", i), 32'(m_cnt[6'h10][1])});
      sb.push_back('{$sformatf("train%0d_mp", i), 32'(tt[i] != p)});
      e = sb.pop_front(); n_cmp++;
      if (32'(b_pred) !== e.exp) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, b_pred, e.exp); end
      e = sb.pop_front(); n_cmp++;
      if (32'(b_mp) !== e.exp) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, b_mp, e.exp); end
      m_train(6'h10, tt[i], tt[i] != p);
    end
    @(negedge clk);
    drive(3'd0, 0, 0, 0, 6'd0, 0, 0);
    #1;
    sb.push_back('{"train_final_pred", 32'(m_cnt[6'h10][1])});
    e = sb.pop_front(); n_cmp++;
    if (32'(b_pred) !== e.exp) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, b_pred, e.exp); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] idx;
    logic       t, p;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      idx   = 6'($urandom_range(0, 7));
      t     = 1'($urandom_range(0, 1));
      p     = m_cnt[idx][1];
      if_pc = {24'd0, idx, 2'b00};
      drive(3'd1, t, 0, p, idx, 1, 0);
      #1;
      sb.push_back('{$sformatf("b2b%0d_pred", i), 32'(m_cnt[idx][1])});
      sb.push_back('{$sformatf("b2b%0d_mp", i), 32'(t != p)});
      e = sb.pop_front(); n_cmp++;
      if (32'(b_pred) !== e.exp) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, b_pred, e.exp); end
      e = sb.pop_front(); n_cmp++;
      if (32'(b_mp) !== e.exp) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, b_mp, e.exp); end
      m_train(idx, t, t != p);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(3'd0, 0, 0, 0, 6'd0, 0, 0);
      if_pc = 32'(i) << 2;
      #1;
      idx = 6'(i) ^ {2'b00, m_ghr};
      sb.push_back('{$sformatf("sweep%0d_bpred", i), 32'(m_cnt[i][1])});
      sb.push_back('{$sformatf("sweep%0d_gidx", i), 32'(idx)});
      sb.push_back('{$sformatf("sweep%0d_gpred", i), 32'(m_cnt[idx][1])});
      e = sb.pop_front(); n_cmp++;
      if (32'(b_pred) !== e.exp) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, b_pred, e.exp); end
      e = sb.pop_front(); n_cmp++;
      if (32'(g_idx) !== e.exp) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, g_idx, e.exp); end
      e = sb.pop_front(); n_cmp++;
      if (32'(g_pred) !== e.exp) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, g_pred, e.exp); end
    end
  endtask

  task automatic test_stall_bubble();
    if_pc = 32'h40;
    @(negedge clk);
    drive(3'd1, 1, 0, 0, 6'h10, 1, 1);
    #1;
    sb.push_back('{"stall_mp", 32'(mp_model(1'b1, 3'd1, 1'b1, 1'b0))});
    e = sb.pop_front(); n_cmp++;
    if (32'(b_mp) !== e.exp) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, b_mp, e.exp); end
    @(negedge clk);
    drive(3'd1, 1, 0, 0, 6'h10, 0, 0);
    #1;
    sb.push_back('{"bubble_mp", 32'(mp_model(1'b0, 3'd1, 1'b1, 1'b0))});
    e = sb.pop_front(); n_cmp++;
    if (32'(b_mp) !== e.exp) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, b_mp, e.exp); end
    @(negedge clk);
    drive(3'd0, 0, 0, 0, 6'd0, 0, 0);
    #1;
    sb.push_back('{"stall_gidx", 32'(6'h10 ^ {2'b00, m_ghr})});
    e = sb.pop_front(); n_cmp++;
    if (32'(g_idx) !== e.exp) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, g_idx, e.exp); end
`ifdef BRANCH_PERF_EN
    sb.push_back('{"stall_perf_br", 32'(m_br)});
    e = sb.pop_front(); n_cmp++;
    if (b_pbr !== e.exp) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, b_pbr, e.exp); end
`endif
    // one real taken resolve: counter 00 -> 01 stays not-taken, unless the
    // stalled/bubble cycles also trained
    drive(3'd1, 1, 0, 0, 6'h10, 1, 0);
    m_train(6'h10, 1'b1, 1'b1);
    @(negedge clk);
    drive(3'd0, 0, 0, 0, 6'd0, 0, 0);
    #1;
    sb.push_back('{"stall_after_pred", 32'(m_cnt[6'h10][1])});
    e = sb.pop_front(); n_cmp++;
    if (32'(b_pred) !== e.exp) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, b_pred, e.exp); end
  endtask

  task automatic test_gshare();
    logic tt [4];
    logic p;
    tt = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      p = m_cnt[6'h20][1];
      drive(3'd1, tt[i], 0, p, 6'h20, 1, 0);
      #1;
      m_train(6'h20, tt[i], tt[i] != p);
    end
    @(negedge clk);
    drive(3'd0, 0, 0, 0, 6'd0, 0, 0);
    if_pc = 32'h40;
    #1;
    sb.push_back('{"gshare_idx", 32'h16});
    sb.push_back('{"gshare_pred", 32'(m_cnt[6'h16][1])});
    sb.push_back('{"bimodal_idx", 32'h10});
    e = sb.pop_front(); n_cmp++;
    if (32'(g_idx) !== e.exp) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, g_idx, e.exp); end
    e = sb.pop_front(); n_cmp++;
    if (32'(g_pred) !== e.exp) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, g_pred, e.exp); end
    e = sb.pop_front(); n_cmp++;
    if (32'(b_idx) !== e.exp) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, b_idx, e.exp); end
  endtask

  task automatic test_reset_mid();
    // bring 0x10 up to a taken prediction first
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(3'd1, 1, 0, m_cnt[6'h10][1], 6'h10, 1, 0);
      #1;
      m_train(6'h10, 1'b1, m_cnt[6'h10][1] != 1'b1);
    end
    @(negedge clk);
    if_pc = 32'h40;
    drive(3'd1, 1, 0, 0, 6'h11, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    sb.push_back('{"midrst_low_pred", 32'd0});
    e = sb.pop_front(); n_cmp++;
    if (32'(b_pred) !== e.exp) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, b_pred, e.exp); end
`ifdef BRANCH_PERF_EN
    sb.push_back('{"midrst_perf_br", 32'd0});
    e = sb.pop_front(); n_cmp++;
    if (b_pbr !== e.exp) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, b_pbr, e.exp); end
`endif
    rst_n = 1'b1;
    m_reset();
    m_train(6'h11, 1'b1, 1'b1);  // the branch still in EX trains at the next edge
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      drive(3'd0, 0, 0, 0, 6'd0, 0, 0);
      if_pc = 32'(i) << 2;
      #1;
      sb.push_back('{$sformatf("midrst_pred%0d", i), 32'(m_cnt[i][1])});
      sb.push_back('{$sformatf("midrst_gidx%0d", i), 32'(6'(i) ^ {2'b00, m_ghr})});
      e = sb.pop_front(); n_cmp++;
      if (32'(b_pred) !== e.exp) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, b_pred, e.exp); end
      e = sb.pop_front(); n_cmp++;
      if (32'(g_idx) !== e.exp) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, g_idx, e.exp); end
    end
  endtask

  task automatic test_perf();
    logic tt [3];
    logic pp [3];
    tt = '{1'b1, 1'b1, 1'b0};
    pp = '{1'b0, 1'b1, 1'b1};
    @(negedge clk);
    drive(3'd0, 0, 0, 0, 6'd0, 0, 0);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    m_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(3'd2, !tt[i], 0, pp[i], 6'h30, 1, 0);
      #1;
      sb.push_back('{$sformatf("perf%0d_mp", i), 32'(tt[i] != pp[i])});
      e = sb.pop_front(); n_cmp++;
      if (32'(b_mp) !== e.exp) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, b_mp, e.exp); end
      m_train(6'h30, tt[i], tt[i] != pp[i]);
    end
    @(negedge clk);
    drive(3'd0, 0, 0, 0, 6'd0, 0, 0);
    #1;
`ifdef BRANCH_PERF_EN
    sb.push_back('{"perf_branches", 32'(m_br)});
    sb.push_back('{"perf_mispred", 32'(m_mp)});
    e = sb.pop_front(); n_cmp++;
    if (b_pbr !== e.exp) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, b_pbr, e.exp); end
    e = sb.pop_front(); n_cmp++;
    if (b_pmp !== e.exp) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, b_pmp, e.exp); end
`endif
    if_pc = 32'hC0;
    #1;
    sb.push_back('{"perf_cnt_pred", 32'(m_cnt[6'h30][1])});
    e = sb.pop_front(); n_cmp++;
    if (32'(b_pred) !== e.exp) begin n_bad++; $display("FAIL %s: got %0h expected %0h", e.name, b_pred, e.exp); end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_train();
    test_back_to_back();
    test_stall_bubble();
    test_gshare();
    test_reset_mid();
    test_perf();
    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule
